// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration serial loader.
// Holds the FSM state codes, default word size and the pad config-word field layout.
package gpio_cfg_pkg;

    localparam int CFG_BITS_DEF = 13;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_CAPT  = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_LOAD  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Bit positions inside one pad config word (bit 0 is shifted last).
    localparam int CFG_MGMT_EN       = 0;
    localparam int CFG_OUTPUT_DIS    = 1;
    localparam int CFG_HOLD_OVERRIDE = 2;
    localparam int CFG_INP_DIS       = 3;
    localparam int CFG_IB_SEL        = 4;
    localparam int CFG_ANALOG_EN     = 5;
    localparam int CFG_ANALOG_SEL    = 6;
    localparam int CFG_ANALOG_POL    = 7;
    localparam int CFG_SLOW_SLEW     = 8;
    localparam int CFG_TRIP_SEL      = 9;
    localparam int CFG_DM_LSB        = 10;
    localparam int CFG_DM_W          = 3;

    function automatic logic is_active(input state_t s);
        return (s == ST_FETCH) || (s == ST_CAPT) || (s == ST_SHIFT) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/gpio_cfg_bit_timer.sv
// Half-period timer for the serial chain: half_tick every CLK_DIV enabled cycles,
// bit_end on every second half_tick (end of one full serial_clock period).
module gpio_cfg_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic half_tick,
    output logic bit_end
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             phase;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (en) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign half_tick = en && (div_cnt == DIV_LAST);
    assign bit_end   = half_tick && phase;

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// Streams per-pad config words (farthest pad first, MSB first) into the pad chain,
// then pulses serial_load once so every pad latches its new word together.
module gpio_cfg_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int IO_PADS  = 38,
    parameter int CFG_BITS = CFG_BITS_DEF,
    parameter int CLK_DIV  = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       start,
    output logic [$clog2(IO_PADS)-1:0] cfg_idx,
    input  logic [CFG_BITS-1:0]        cfg_data,
    output logic                       serial_clock,
    output logic                       serial_data_out,
    output logic                       serial_load,
    output logic                       busy,
    output logic                       done,
    output state_t                     fsm_state
);

    localparam int IDX_W = $clog2(IO_PADS);
    localparam int BIT_W = $clog2(CFG_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IO_PADS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);

    state_t              state;
    logic [CFG_BITS-2:0] pend_bits;
    logic [BIT_W-1:0]    bit_cnt;
    logic                half_tick;
    logic                bit_end;
    logic                timer_en;
    logic                timer_clear;
    logic                last_bit;

    assign last_bit    = (bit_cnt == '0);
    assign timer_en    = (state == ST_SHIFT) || (state == ST_LOAD);
    // Restart the half-period count on the way into SHIFT and into LOAD.
    assign timer_clear = (state == ST_CAPT) ||
                         ((state == ST_SHIFT) && bit_end && last_bit && (cfg_idx == '0));

    gpio_cfg_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .clear     (timer_clear),
        .en        (timer_en),
        .half_tick (half_tick),
        .bit_end   (bit_end)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= ST_IDLE;
            cfg_idx         <= IDX_LAST;
            pend_bits       <= '0;
            bit_cnt         <= '0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        cfg_idx <= IDX_LAST;
                    end
                end
                ST_FETCH: begin
                    state <= ST_CAPT;
                end
                ST_CAPT: begin
                    // The MSB goes straight to the data flop so it is on the wire for the first low half.
                    pend_bits       <= cfg_data[CFG_BITS-2:0];
                    serial_data_out <= cfg_data[CFG_BITS-1];
                    serial_clock    <= 1'b0;
                    bit_cnt         <= BIT_LAST;
                    state           <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        serial_clock <= 1'b0;
                        if (last_bit) begin
                            if (cfg_idx == '0) begin
                                serial_data_out <= 1'b0;
                                serial_load     <= 1'b1;
                                state           <= ST_LOAD;
                            end else begin
                                cfg_idx <= cfg_idx - 1'b1;
                                state   <= ST_FETCH;
                            end
                        end else begin
                            serial_data_out <= pend_bits[CFG_BITS-2];
                            pend_bits       <= pend_bits << 1;
                            bit_cnt         <= bit_cnt - 1'b1;
                        end
                    end else if (half_tick) begin
                        serial_clock <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (half_tick) begin
                        serial_load <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cfg_idx <= IDX_LAST;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = is_active(state);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Bench for gpio_cfg_serial_loader: a small 2-pad chain for the timing corner cases
// and a full 38-pad chain, each followed by a behavioural pad-chain model.
module tb_gpio_cfg_serial_loader;
    import gpio_cfg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- small DUT: 2 pads x 4 bits, CLK_DIV=1 ----------------
    logic       s_rst = 1'b1;
    logic       s_start = 1'b0;
    logic [0:0] s_cfg_idx;
    logic [3:0] s_cfg_data = '0;
    logic       s_sclk, s_sdo, s_load, s_busy, s_done;
    state_t     s_fsm_state;
    logic [3:0] s_regs [2];

    gpio_cfg_serial_loader #(.IO_PADS(2), .CFG_BITS(4), .CLK_DIV(1)) u_small (
        .wb_clk_i        (clk),
        .wb_rst_i        (s_rst),
        .start           (s_start),
        .cfg_idx         (s_cfg_idx),
        .cfg_data        (s_cfg_data),
        .serial_clock    (s_sclk),
        .serial_data_out (s_sdo),
        .serial_load     (s_load),
        .busy            (s_busy),
        .done            (s_done),
        .fsm_state       (s_fsm_state)
    );

    always @(posedge clk) s_cfg_data <= s_regs[s_cfg_idx];

    // ---------------- full DUT: 38 pads x 13 bits, CLK_DIV=4 ----------------
    logic        b_rst = 1'b1;
    logic        b_start = 1'b0;
    logic [5:0]  b_cfg_idx;
    logic [12:0] b_cfg_data = '0;
    logic        b_sclk, b_sdo, b_load, b_busy, b_done;
    state_t      b_fsm_state;
    logic [12:0] b_regs [38];

    gpio_cfg_serial_loader #(.IO_PADS(38), .CFG_BITS(13), .CLK_DIV(4)) u_full (
        .wb_clk_i        (clk),
        .wb_rst_i        (b_rst),
        .start           (b_start),
        .cfg_idx         (b_cfg_idx),
        .cfg_data        (b_cfg_data),
        .serial_clock    (b_sclk),
        .serial_data_out (b_sdo),
        .serial_load     (b_load),
        .busy            (b_busy),
        .done            (b_done),
        .fsm_state       (b_fsm_state)
    );

    always @(posedge clk) b_cfg_data <= b_regs[b_cfg_idx];

    // ---------------- pad chain models (sampled on the falling edge) ----------------
    logic [7:0] s_chain = '0;
    logic [7:0] s_latched = '0;
    logic       s_sclk_q = 1'b0;
    logic       s_sdo_q = 1'b0;
    int         s_rises = 0;
    int         s_load_n = 0;
    int         s_glitch = 0;
    int         s_overlap = 0;

    always @(negedge clk) begin
        if (s_sclk && !s_sclk_q) begin
            s_chain <= {s_chain[6:0], s_sdo};
            s_rises <= s_rises + 1;
        end
        if (s_sclk && s_sclk_q && (s_sdo != s_sdo_q)) s_glitch <= s_glitch + 1;
        if (s_load && s_sclk) s_overlap <= s_overlap + 1;
        if (s_load) begin
            s_latched <= s_chain;
            s_load_n  <= s_load_n + 1;
        end
        s_sclk_q <= s_sclk;
        s_sdo_q  <= s_sdo;
    end

    logic [493:0] b_chain = '0;
    logic [493:0] b_latched = '0;
    logic         b_sclk_q = 1'b0;
    int           b_rises = 0;

    always @(negedge clk) begin
        if (b_sclk && !b_sclk_q) begin
            b_chain <= {b_chain[492:0], b_sdo};
            b_rises <= b_rises + 1;
        end
        if (b_load) b_latched <= b_chain;
        b_sclk_q <= b_sclk;
    end

    // ---------------- driver tasks ----------------
    task automatic s_pulse_start();
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    // Entered at the falling edge of the first cycle after the accept edge.
    task automatic s_wait_done(input int mid, output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (!s_done && lat < 200) begin
            if (s_busy) busy_n++;
            s_start = (lat == mid);
            @(negedge clk);
            lat++;
        end
        s_start = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] c1;
        logic [3:0] c0;
        int         mid;
        logic [7:0] exp_word;
        int         exp_lat;
        int         exp_busy;
    } vec_t;

    vec_t vecs [5];

    int lat, bn, extra;
    int r0, l0, g0, o0;
    logic [7:0] keep;

    initial begin
        vecs[0] = '{4'hA, 4'h3, 0,  8'hA3, 22, 21};
        vecs[1] = '{4'h5, 4'hC, 10, 8'h5C, 22, 21};
        vecs[2] = '{4'hF, 4'h0, 5,  8'hF0, 22, 21};
        vecs[3] = '{4'h0, 4'hF, 0,  8'h0F, 22, 21};
        vecs[4] = '{4'h9, 4'h6, 19, 8'h96, 22, 21};
        s_regs[0] = '0;
        s_regs[1] = '0;
        for (int p = 0; p < 38; p++) b_regs[p] = '0;

        repeat (3) @(negedge clk);
        chk("rst_sclk", s_sclk, 1'b0);
        chk("rst_sdo", s_sdo, 1'b0);
        chk("rst_load", s_load, 1'b0);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_done", s_done, 1'b0);
        chk("rst_idx", s_cfg_idx, 1'b1);
        chk("rst_state", s_fsm_state, ST_IDLE);
        chk("rst_full_idx", b_cfg_idx, 6'd37);
        s_rst = 1'b0;
        b_rst = 1'b0;

        // Table: full loads, some with a stray start in the middle.
        for (int i = 0; i < 5; i++) begin
            s_regs[1] = vecs[i].c1;
            s_regs[0] = vecs[i].c0;
            r0 = s_rises; l0 = s_load_n; g0 = s_glitch; o0 = s_overlap;
            s_pulse_start();
            s_wait_done(vecs[i].mid, lat, bn);
            chk("latency", lat, vecs[i].exp_lat);
            chk("busy_cycles", bn, vecs[i].exp_busy);
            chk("done_busy_low", s_busy, 1'b0);
            chk("done_state", s_fsm_state, ST_DONE);
            chk("latched", s_latched, vecs[i].exp_word);
            chk("sclk_rises", s_rises - r0, 8);
            chk("load_cycles", s_load_n - l0, 1);
            chk("sdo_stable_hi", s_glitch - g0, 0);
            chk("load_overlap", s_overlap - o0, 0);
            extra = 0;
            repeat (20) begin
                @(negedge clk);
                if (s_done || s_busy) extra++;
            end
            chk("no_second_run", extra, 0);
        end

        // Reset during the third bit (cycles 7-8 after accept).
        keep = s_latched;
        l0 = s_load_n;
        s_regs[1] = 4'h1;
        s_regs[0] = 4'h2;
        s_pulse_start();
        repeat (6) @(negedge clk);
        chk("mid_busy", s_busy, 1'b1);
        s_rst = 1'b1;
        @(negedge clk);
        chk("abort_sclk", s_sclk, 1'b0);
        chk("abort_sdo", s_sdo, 1'b0);
        chk("abort_load", s_load, 1'b0);
        chk("abort_busy", s_busy, 1'b0);
        chk("abort_done", s_done, 1'b0);
        chk("abort_state", s_fsm_state, ST_IDLE);
        chk("abort_idx", s_cfg_idx, 1'b1);
        s_rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_no_load", s_load_n - l0, 0);
        chk("abort_keep_cfg", s_latched, keep);
        s_pulse_start();
        s_wait_done(0, lat, bn);
        chk("post_abort_latency", lat, 22);
        @(negedge clk);
        chk("post_abort_latched", s_latched, 8'h12);

        // Back-to-back: start held through the DONE cycle and the following IDLE cycle.
        s_regs[1] = 4'hB;
        s_regs[0] = 4'h4;
        s_pulse_start();
        s_wait_done(0, lat, bn);
        chk("b2b_first_latency", lat, 22);
        chk("b2b_first_latched", s_latched, 8'hB4);
        s_start = 1'b1;
        s_regs[1] = 4'h7;
        s_regs[0] = 4'hE;
        @(negedge clk);
        chk("b2b_done_start_ignored", s_busy, 1'b0);
        chk("b2b_idle_state", s_fsm_state, ST_IDLE);
        @(negedge clk);
        s_start = 1'b0;
        chk("b2b_accepted", s_busy, 1'b1);
        s_wait_done(0, lat, bn);
        chk("b2b_second_latency", lat, 22);
        @(negedge clk);
        chk("b2b_second_latched", s_latched, 8'h7E);

        // Full-size chain with random words.
        for (int p = 0; p < 38; p++) b_regs[p] = 13'($urandom_range(0, 8191));
        r0 = b_rises;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        lat = 1;
        bn = 0;
        while (!b_done && lat < 5000) begin
            if (b_busy) bn++;
            @(negedge clk);
            lat++;
        end
        chk("full_latency", lat, 4033);
        chk("full_busy_cycles", bn, 4032);
        @(negedge clk);
        chk("full_sclk_rises", b_rises - r0, 494);
        for (int p = 0; p < 38; p++) begin
            chk($sformatf("full_pad%0d", p), 32'(b_latched[p*13 +: 13]), 32'(b_regs[p]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
